// File: rtl/zap_copro_pkg.sv
// rtl/zap_copro_pkg.sv - shared types and constants for the coprocessor bridge
// Purpose: state encoding, coprocessor-number field position and the CP15 constant,
//          plus a helper that extracts the coprocessor number from an instruction.
// Ports:   none (package).
package zap_copro_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } copro_state_t;

   localparam int         CP_NUM_LSB = 8;
   localparam int         CP_NUM_MSB = 11;
   localparam logic [3:0] CP15       = 4'd15;

   function automatic logic [3:0] cp_num_of(input logic [31:0] word);
      return word[CP_NUM_MSB:CP_NUM_LSB];
   endfunction

endpackage

// File: rtl/zap_copro_timeout.sv
// rtl/zap_copro_timeout.sv - saturating wait-cycle counter for the coprocessor bridge
// Purpose: counts enabled cycles since the last clear; flags expiry on the
//          TIMEOUT_CYCLES-th enabled cycle. Only instantiated with ZAP_COPRO_TIMEOUT_EN.
// Ports:   i_clk, i_reset_n (async active-low), i_clear (restart count),
//          i_enable (count this cycle), o_expired (limit reached this cycle).
module zap_copro_timeout #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int             CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count <= '0;
      end else if (i_clear) begin
         count <= '0;
      end else if (i_enable && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   // The count of the current cycle is 0 on the first enabled cycle, so the
   // limit cycle is the one whose count equals TIMEOUT_CYCLES-1.
   assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/zap_copro_bridge.sv
// rtl/zap_copro_bridge.sv - issues predecoded coprocessor words over a req/ack channel
// Purpose: takes the held dav/word pair, sends the word to the addressed external
//          coprocessor, waits for its response and returns a level done (with undef
//          for absent, rejecting or timed-out coprocessors). Flushes mid-operation
//          drain any owed response before the next request.
// Ports:   i_clk, i_reset_n (async active-low); i_copro_dav/i_copro_word from predecode;
//          o_copro_done/o_copro_undef back to decode; o_cp_req/o_cp_word/o_cp_num,
//          i_cp_ack, i_cp_resp_valid/i_cp_resp_err on the coprocessor side.
// Config:  ZAP_COPRO_TIMEOUT_EN adds a REQ/WAIT timeout of TIMEOUT_CYCLES cycles.
module zap_copro_bridge
   import zap_copro_pkg::*;
#(
   parameter logic [15:0] CP_PRESENT     = 16'h0001 << CP15,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_copro_dav,
   input  logic [31:0] i_copro_word,
   output logic        o_copro_done,
   output logic        o_copro_undef,
   output logic        o_cp_req,
   output logic [31:0] o_cp_word,
   output logic [3:0]  o_cp_num,
   input  logic        i_cp_ack,
   input  logic        i_cp_resp_valid,
   input  logic        i_cp_resp_err
);

   copro_state_t state, state_n;
   logic         undef_n;
   logic [31:0]  word_n;
   logic [3:0]   num_n;
   logic         drain_pend, drain_pend_n;   // response still owed after a timeout
   logic         timeout_expired;

`ifdef ZAP_COPRO_TIMEOUT_EN
   zap_copro_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clear   ((state_n == ST_REQ) && (state != ST_REQ)),
      .i_enable  ((state == ST_REQ) || (state == ST_WAIT)),
      .o_expired (timeout_expired)
   );
`else
   assign timeout_expired = 1'b0;
`endif

   always_comb begin
      state_n      = state;
      undef_n      = o_copro_undef;
      word_n       = o_cp_word;
      num_n        = o_cp_num;
      drain_pend_n = drain_pend;
      case (state)
         ST_IDLE: begin
            if (i_copro_dav) begin
               word_n = i_copro_word;
               num_n  = cp_num_of(i_copro_word);
               if (CP_PRESENT[cp_num_of(i_copro_word)]) begin
                  state_n = ST_REQ;
                  undef_n = 1'b0;
               end else begin
                  state_n = ST_DONE;
                  undef_n = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (!i_copro_dav) begin
               // An accepted request still owes a response unless it came with the ack.
               state_n = (i_cp_ack && !i_cp_resp_valid) ? ST_DRAIN : ST_IDLE;
            end else if (i_cp_ack && i_cp_resp_valid) begin
               state_n = ST_DONE;
               undef_n = i_cp_resp_err;
            end else if (i_cp_ack) begin
               state_n = ST_WAIT;
            end else if (timeout_expired) begin
               state_n = ST_DONE;
               undef_n = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!i_copro_dav) begin
               state_n = i_cp_resp_valid ? ST_IDLE : ST_DRAIN;
            end else if (i_cp_resp_valid) begin
               state_n = ST_DONE;
               undef_n = i_cp_resp_err;
            end else if (timeout_expired) begin
               state_n      = ST_DONE;
               undef_n      = 1'b1;
               drain_pend_n = 1'b1;
            end
         end
         ST_DONE: begin
            if (i_cp_resp_valid) begin
               drain_pend_n = 1'b0;
            end
            if (!i_copro_dav) begin
               undef_n = 1'b0;
               state_n = (drain_pend && !i_cp_resp_valid) ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (i_cp_resp_valid) begin
               state_n      = ST_IDLE;
               drain_pend_n = 1'b0;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= ST_IDLE;
         o_cp_req      <= 1'b0;
         o_copro_done  <= 1'b0;
         o_copro_undef <= 1'b0;
         o_cp_word     <= '0;
         o_cp_num      <= '0;
         drain_pend    <= 1'b0;
      end else begin
         state         <= state_n;
         o_cp_req      <= (state_n == ST_REQ);
         o_copro_done  <= (state_n == ST_DONE);
         o_copro_undef <= (state_n == ST_DONE) && undef_n;
         o_cp_word     <= word_n;
         o_cp_num      <= num_n;
         drain_pend    <= drain_pend_n;
      end
   end

endmodule
